// File: rtl/apb_master_arbiter.sv
// Two-requester round-robin APB master: REQ/ACK command ports in, one APB bus out.
// Optional ACCESS-phase timeout is compiled in with `define APB_ARB_TIMEOUT_EN.
module apb_master_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 255
) (
    input  logic          HCLK,
    input  logic          HRESETn,
    input  logic          PCLKEN,
    input  logic          REQ0,
    input  logic [AW-1:0] ADDR0,
    input  logic          WRITE0,
    input  logic [DW-1:0] WDATA0,
    input  logic          REQ1,
    input  logic [AW-1:0] ADDR1,
    input  logic          WRITE1,
    input  logic [DW-1:0] WDATA1,
    output logic          ACK0,
    output logic          ACK1,
    output logic [DW-1:0] RDATA,
    output logic          ERR,
    output logic [AW-1:0] PADDR,
    output logic          PWRITE,
    output logic [DW-1:0] PWDATA,
    output logic          PSEL,
    output logic          PENABLE,
    input  logic [DW-1:0] PRDATA,
    input  logic          PREADY,
    input  logic          PSLVERR
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } state_e;

    if (TIMEOUT < 1 || TIMEOUT > 65535) begin : g_timeout_range
        $error("apb_master_arbiter: TIMEOUT must be within 1..65535");
    end

    // With both requesters eligible the one that did not go last wins.
    function automatic logic pick_winner(input logic elig0, input logic elig1, input logic last);
        logic win;
        if (elig0 && elig1) begin
            win = ~last;
        end else begin
            win = elig1;
        end
        return win;
    endfunction

    state_e          state_q, state_d;
    logic            last_q, last_d;
    logic            grant_q, grant_d;
    logic            psel_q, psel_d;
    logic            penable_q, penable_d;
    logic [AW-1:0]   paddr_q, paddr_d;
    logic            pwrite_q, pwrite_d;
    logic [DW-1:0]   pwdata_q, pwdata_d;
    logic            ack0_q, ack0_d;
    logic            ack1_q, ack1_d;
    logic [DW-1:0]   rdata_q, rdata_d;
    logic            err_q, err_d;

    logic            elig0_s;
    logic            elig1_s;
    logic            winner_s;
    logic            abort_s;

    // A requester is masked in its own ACK cycle so a held REQ is not re-granted.
    assign elig0_s  = REQ0 & ~ack0_q;
    assign elig1_s  = REQ1 & ~ack1_q;
    assign winner_s = pick_winner(elig0_s, elig1_s, last_q);

`ifdef APB_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] tcnt_q, tcnt_d;

    // Wait-state counter: cleared on ACCESS entry, counts enabled cycles without PREADY.
    always_comb begin
        tcnt_d  = tcnt_q;
        abort_s = 1'b0;
        if (state_q == ST_SETUP && PCLKEN) begin
            tcnt_d = {CW{1'b0}};
        end else if (state_q == ST_ACCESS && PCLKEN && !PREADY) begin
            if (tcnt_q == CW'(TIMEOUT - 1)) begin
                abort_s = 1'b1;
            end else begin
                tcnt_d = tcnt_q + CW'(1'b1);
            end
        end else begin
            tcnt_d = tcnt_q;
        end
    end

    // Wait-state counter register.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            tcnt_q <= {CW{1'b0}};
        end else begin
            tcnt_q <= tcnt_d;
        end
    end
`else
    assign abort_s = 1'b0;
`endif

    // Arbitration, APB phase sequencing and completion handling.
    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        grant_d   = grant_q;
        psel_d    = psel_q;
        penable_d = penable_q;
        paddr_d   = paddr_q;
        pwrite_d  = pwrite_q;
        pwdata_d  = pwdata_q;
        ack0_d    = 1'b0;
        ack1_d    = 1'b0;
        rdata_d   = rdata_q;
        err_d     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if ((elig0_s || elig1_s) && PCLKEN) begin
                    grant_d   = winner_s;
                    paddr_d   = winner_s ? ADDR1 : ADDR0;
                    pwrite_d  = winner_s ? WRITE1 : WRITE0;
                    pwdata_d  = winner_s ? WDATA1 : WDATA0;
                    psel_d    = 1'b1;
                    penable_d = 1'b0;
                    state_d   = ST_SETUP;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SETUP: begin
                if (PCLKEN) begin
                    penable_d = 1'b1;
                    state_d   = ST_ACCESS;
                end else begin
                    state_d = ST_SETUP;
                end
            end
            ST_ACCESS: begin
                // A real PREADY wins over a timeout landing on the same edge.
                if (PCLKEN && PREADY) begin
                    ack0_d    = ~grant_q;
                    ack1_d    = grant_q;
                    rdata_d   = PRDATA;
                    err_d     = PSLVERR;
                    psel_d    = 1'b0;
                    penable_d = 1'b0;
                    last_d    = grant_q;
                    state_d   = ST_IDLE;
                end else if (abort_s) begin
                    ack0_d    = ~grant_q;
                    ack1_d    = grant_q;
                    rdata_d   = {DW{1'b0}};
                    err_d     = 1'b1;
                    psel_d    = 1'b0;
                    penable_d = 1'b0;
                    last_d    = grant_q;
                    state_d   = ST_IDLE;
                end else begin
                    state_d = ST_ACCESS;
                end
            end
            default: begin
                psel_d    = 1'b0;
                penable_d = 1'b0;
                state_d   = ST_IDLE;
            end
        endcase
    end

    // State, arbitration history and all registered outputs.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q   <= ST_IDLE;
            last_q    <= 1'b1;
            grant_q   <= 1'b0;
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            paddr_q   <= {AW{1'b0}};
            pwrite_q  <= 1'b0;
            pwdata_q  <= {DW{1'b0}};
            ack0_q    <= 1'b0;
            ack1_q    <= 1'b0;
            rdata_q   <= {DW{1'b0}};
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            grant_q   <= grant_d;
            psel_q    <= psel_d;
            penable_q <= penable_d;
            paddr_q   <= paddr_d;
            pwrite_q  <= pwrite_d;
            pwdata_q  <= pwdata_d;
            ack0_q    <= ack0_d;
            ack1_q    <= ack1_d;
            rdata_q   <= rdata_d;
            err_q     <= err_d;
        end
    end

    assign ACK0    = ack0_q;
    assign ACK1    = ack1_q;
    assign RDATA   = rdata_q;
    assign ERR     = err_q;
    assign PADDR   = paddr_q;
    assign PWRITE  = pwrite_q;
    assign PWDATA  = pwdata_q;
    assign PSEL    = psel_q;
    assign PENABLE = penable_q;

endmodule

// File: tb/tb_apb_master_arbiter.sv
// Self-checking bench for apb_master_arbiter: vector table, scoreboard and corner-case sequences.
module tb_apb_master_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;

    logic          HCLK = 1'b0;
    logic          HRESETn = 1'b1;
    logic          PCLKEN = 1'b1;
    logic          REQ0 = 1'b0, WRITE0 = 1'b0, REQ1 = 1'b0, WRITE1 = 1'b0;
    logic [AW-1:0] ADDR0 = '0, ADDR1 = '0;
    logic [DW-1:0] WDATA0 = '0, WDATA1 = '0, PRDATA = '0;
    logic          PREADY = 1'b0, PSLVERR = 1'b0;
    logic          ACK0, ACK1, ERR, PWRITE, PSEL, PENABLE;
    logic [DW-1:0] RDATA, PWDATA;
    logic [AW-1:0] PADDR;

    apb_master_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(4)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .PCLKEN(PCLKEN),
        .REQ0(REQ0), .ADDR0(ADDR0), .WRITE0(WRITE0), .WDATA0(WDATA0),
        .REQ1(REQ1), .ADDR1(ADDR1), .WRITE1(WRITE1), .WDATA1(WDATA1),
        .ACK0(ACK0), .ACK1(ACK1), .RDATA(RDATA), .ERR(ERR),
        .PADDR(PADDR), .PWRITE(PWRITE), .PWDATA(PWDATA), .PSEL(PSEL), .PENABLE(PENABLE),
        .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
    );

    always #5 HCLK = ~HCLK;

    typedef struct {
        logic          who;
        logic [AW-1:0] addr;
        logic          write;
        logic [DW-1:0] wdata;
        logic [DW-1:0] rdata;
        logic          err;
    } exp_t;

    typedef struct {
        logic          who;
        logic          write;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        int            waits;
        logic [DW-1:0] prdata;
        logic          slverr;
        logic          div2;
        logic [DW-1:0] exp_rdata;
        logic          exp_err;
        int            exp_lat;
    } vec_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    logic exp_last = 1'b1;
    int   s_waited = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_exp(input logic who, input logic [AW-1:0] addr, input logic write,
                            input logic [DW-1:0] wdata, input logic [DW-1:0] rdata, input logic err);
        exp_t e;
        e.who = who; e.addr = addr; e.write = write; e.wdata = wdata; e.rdata = rdata; e.err = err;
        sb.push_back(e);
        exp_last = who;
    endtask

    task automatic drive_req(input logic who, input logic [AW-1:0] addr, input logic write,
                             input logic [DW-1:0] wdata);
        if (who) begin
            REQ1 = 1'b1; ADDR1 = addr; WRITE1 = write; WDATA1 = wdata;
        end else begin
            REQ0 = 1'b1; ADDR0 = addr; WRITE0 = write; WDATA0 = wdata;
        end
    endtask

    task automatic drop_req(input logic who);
        if (who) REQ1 = 1'b0;
        else     REQ0 = 1'b0;
    endtask

    // Slave model: holds PREADY low for 'waits' enabled ACCESS edges, then responds.
    task automatic slave_step(input int waits, input logic [DW-1:0] rd, input logic se);
        if (PSEL && PENABLE) begin
            if (s_waited < waits) begin
                PREADY = 1'b0; PSLVERR = 1'b0; PRDATA = 32'h0BAD_0000;
                if (PCLKEN) s_waited++;
            end else begin
                PREADY = 1'b1; PSLVERR = se; PRDATA = rd;
            end
        end else begin
            s_waited = 0; PREADY = 1'b0; PSLVERR = 1'b0; PRDATA = 32'h0BAD_0000;
        end
    endtask

    task automatic run_xfer(input vec_t v);
        logic acked = 1'b0;
        logic done = 1'b0;
        int   lat = 0;
        drive_req(v.who, v.addr, v.write, v.wdata);
        push_exp(v.who, v.addr, v.write, v.wdata, v.exp_rdata, v.exp_err);
        PCLKEN = v.div2 ? ~PCLKEN : 1'b1;
        slave_step(v.waits, v.prdata, v.slverr);
        for (int c = 1; c <= 100 && !done; c++) begin
            @(negedge HCLK);
            if (acked) begin
                drop_req(v.who);
                done = 1'b1;
            end else begin
                if (PSEL) chk("paddr_hold", PADDR, v.addr);
                if (v.who ? ACK1 : ACK0) begin
                    acked = 1'b1;
                    lat = c;
                end
                PCLKEN = v.div2 ? ~PCLKEN : 1'b1;
                slave_step(v.waits, v.prdata, v.slverr);
            end
        end
        if (!done) begin
            checks++; errors++;
            $display("FAIL xfer_timeout: no ACK for addr %0h", v.addr);
            drop_req(v.who);
        end else if (v.exp_lat > 0) begin
            chk("latency", lat, v.exp_lat);
        end
    endtask

    task automatic run_pair(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
        logic first;
        logic drop0 = 1'b0, drop1 = 1'b0;
        int   got = 0;
        drive_req(1'b0, a0, 1'b0, 32'h0);
        drive_req(1'b1, a1, 1'b0, 32'h0);
        first = ~exp_last;
        push_exp(first, first ? a1 : a0, 1'b0, 32'h0, first ? ~a1 : ~a0, 1'b0);
        push_exp(~first, first ? a0 : a1, 1'b0, 32'h0, first ? ~a0 : ~a1, 1'b0);
        PCLKEN = 1'b1;
        slave_step(0, ~PADDR, 1'b0);
        for (int c = 0; c < 100 && !(got == 2 && !REQ0 && !REQ1); c++) begin
            @(negedge HCLK);
            if (drop0) begin REQ0 = 1'b0; drop0 = 1'b0; end
            if (drop1) begin REQ1 = 1'b0; drop1 = 1'b0; end
            if (ACK0) begin got++; drop0 = 1'b1; end
            if (ACK1) begin got++; drop1 = 1'b1; end
            PCLKEN = 1'b1;
            slave_step(0, ~PADDR, 1'b0);
        end
        if (got != 2 || REQ0 || REQ1) begin
            checks++; errors++;
            $display("FAIL pair_timeout: acks %0d", got);
            REQ0 = 1'b0; REQ1 = 1'b0;
        end
    endtask

    // Scoreboard monitor: every ACK pops the oldest expectation and compares it.
    always @(negedge HCLK) begin
        if (HRESETn) begin
            if (ACK0 || ACK1) begin
                if (sb.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_ack: got %b expected none", {ACK1, ACK0});
                end else begin
                    mon_e = sb.pop_front();
                    chk("ack_who", {ACK1, ACK0}, mon_e.who ? 2'b10 : 2'b01);
                    chk("rdata", RDATA, mon_e.rdata);
                    chk("err", ERR, mon_e.err);
                    chk("paddr", PADDR, mon_e.addr);
                    chk("pwrite", PWRITE, mon_e.write);
                    chk("pwdata", PWDATA, mon_e.wdata);
                end
            end else begin
                chk("err_without_ack", ERR, 1'b0);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        vecs[6];
        logic [5:0]  pk_pat, psel_pat, pen_pat, ack_pat;
        int          n;
        int          lat;

        // who, write, addr, wdata, waits, prdata, slverr, div2, exp_rdata, exp_err, exp_lat
        vecs[0] = '{1'b1, 1'b0, 32'h4000_0200, 32'h0,          3, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'hDEAD_BEEF, 1'b0, 6};
        vecs[1] = '{1'b0, 1'b1, 32'h4000_0014, 32'h1234_ABCD,  0, 32'h0000_5555, 1'b1, 1'b0, 32'h0000_5555, 1'b1, 3};
        vecs[2] = '{1'b0, 1'b0, 32'h4000_0018, 32'h0,          1, 32'hCAFE_F00D, 1'b0, 1'b0, 32'hCAFE_F00D, 1'b0, 4};
        vecs[3] = '{1'b1, 1'b1, 32'h4000_0104, 32'h5A5A_A5A5,  2, 32'h0000_0000, 1'b0, 1'b1, 32'h0000_0000, 1'b0, 0};
        vecs[4] = '{1'b1, 1'b0, 32'h4000_0108, 32'h0,          0, 32'h8000_0001, 1'b1, 1'b1, 32'h8000_0001, 1'b1, 0};
        vecs[5] = '{1'b0, 1'b0, 32'h4000_0FFC, 32'h0,          0, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'hFFFF_FFFF, 1'b0, 3};

        #1 HRESETn = 1'b0;
        repeat (3) @(negedge HCLK);
        chk("rst_ctrl", {PSEL, PENABLE, PWRITE, ACK0, ACK1, ERR}, 6'b0);
        chk("rst_paddr", PADDR, 32'h0);
        chk("rst_pwdata", PWDATA, 32'h0);
        chk("rst_rdata", RDATA, 32'h0);
        HRESETn = 1'b1;
        exp_last = 1'b1;
        @(negedge HCLK);

        // Single zero-wait write: PSEL +1, PENABLE +2, ACK0 +3, no regrant on held REQ0.
        drive_req(1'b0, 32'h4000_0010, 1'b1, 32'hA5A5_0001);
        push_exp(1'b0, 32'h4000_0010, 1'b1, 32'hA5A5_0001, 32'h1111_2222, 1'b0);
        PCLKEN = 1'b1; PREADY = 1'b1; PSLVERR = 1'b0; PRDATA = 32'h1111_2222;
        @(negedge HCLK);
        chk("w1_setup", {PSEL, PENABLE, PWRITE}, 3'b101);
        chk("w1_paddr", PADDR, 32'h4000_0010);
        chk("w1_pwdata", PWDATA, 32'hA5A5_0001);
        @(negedge HCLK);
        chk("w1_access", {PSEL, PENABLE, ACK0}, 3'b110);
        @(negedge HCLK);
        chk("w1_ack", {ACK0, ACK1, ERR, PSEL, PENABLE}, 5'b10000);
        PRDATA = 32'h0;
        @(negedge HCLK);
        chk("w1_masked", {ACK0, PSEL}, 2'b00);
        chk("w1_rdata_hold", RDATA, 32'h1111_2222);
        REQ0 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge HCLK);
            chk("w1_no_second", PSEL, 1'b0);
        end

        for (int i = 0; i < 6; i++) run_xfer(vecs[i]);

        run_pair(32'h4000_0020, 32'h4000_0220);

        // PCLKEN at half rate with a slave error on completion.
        pk_pat = 6'b101010; psel_pat = 6'b011110; pen_pat = 6'b011000; ack_pat = 6'b100000;
        drive_req(1'b1, 32'h4000_0300, 1'b0, 32'h0);
        push_exp(1'b1, 32'h4000_0300, 1'b0, 32'h0, 32'h1234_5678, 1'b1);
        PCLKEN = pk_pat[0]; PREADY = 1'b1; PSLVERR = 1'b1; PRDATA = 32'h1234_5678;
        for (int i = 0; i < 6; i++) begin
            @(negedge HCLK);
            chk("div2_phase", {PSEL, PENABLE, ACK1}, {psel_pat[i], pen_pat[i], ack_pat[i]});
            if (i < 5) PCLKEN = pk_pat[i+1];
        end
        PCLKEN = 1'b1; PSLVERR = 1'b0; PREADY = 1'b0;
        @(negedge HCLK);
        REQ1 = 1'b0;
        @(negedge HCLK);

        // Reset asserted mid-ACCESS: everything clears at once, no ACK follows.
        drive_req(1'b0, 32'h4000_0500, 1'b1, 32'h7777_0000);
        PCLKEN = 1'b1; PREADY = 1'b0;
        n = 0;
        while (!PENABLE && n < 10) begin
            @(negedge HCLK);
            n++;
        end
        chk("rst_mid_reached_access", PENABLE, 1'b1);
        HRESETn = 1'b0;
        #1;
        chk("rst_mid_ctrl", {PSEL, PENABLE, PWRITE, ACK0, ACK1, ERR}, 6'b0);
        chk("rst_mid_paddr", PADDR, 32'h0);
        chk("rst_mid_pwdata", PWDATA, 32'h0);
        chk("rst_mid_rdata", RDATA, 32'h0);
        REQ0 = 1'b0;
        @(negedge HCLK);
        HRESETn = 1'b1;
        exp_last = 1'b1;
        @(negedge HCLK);

        run_pair(32'h4000_0030, 32'h4000_0230);
        run_pair(32'h4000_0040, 32'h4000_0240);

`ifdef APB_ARB_TIMEOUT_EN
        // Slave never ready: abort after four enabled ACCESS cycles.
        drive_req(1'b0, 32'h4000_0400, 1'b0, 32'h0);
        push_exp(1'b0, 32'h4000_0400, 1'b0, 32'h0, 32'h0, 1'b1);
        PCLKEN = 1'b1;
        slave_step(1000, 32'h0, 1'b0);
        lat = 0;
        for (int c = 1; c <= 50 && lat == 0; c++) begin
            @(negedge HCLK);
            if (ACK0) lat = c;
            slave_step(1000, 32'h0, 1'b0);
        end
        chk("timeout_latency", lat, 6);
        @(negedge HCLK);
        REQ0 = 1'b0;
        @(negedge HCLK);
`else
        // Without the timeout a never-ready slave stalls the bus indefinitely.
        drive_req(1'b0, 32'h4000_0400, 1'b0, 32'h0);
        PCLKEN = 1'b1;
        slave_step(1000, 32'h0, 1'b0);
        n = 0;
        for (int c = 0; c < 60; c++) begin
            @(negedge HCLK);
            if (ACK0 || ACK1) n++;
            slave_step(1000, 32'h0, 1'b0);
        end
        chk("no_timeout_ack", n, 0);
        chk("still_access", {PSEL, PENABLE}, 2'b11);
        HRESETn = 1'b0;
        REQ0 = 1'b0;
        @(negedge HCLK);
        HRESETn = 1'b1;
        @(negedge HCLK);
`endif

        repeat (5) @(negedge HCLK);
        chk("sb_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/apb_master_arbiter.md
Name: apb_master_arbiter

Overview:
Shares one APB master bus between two independent requesters, for example an AHB-to-APB bridge path and a DMA or debug engine. Each requester uses a simple REQ/ACK command port. The block arbitrates round-robin, sequences the APB SETUP/ACCESS phases at the PCLKEN rate, and returns read data and error status to the winning requester. It sits between the requesters and the APB peripheral fabric, in the HCLK domain.

Parameters:
AW, 32, address width of ADDRn and PADDR.
DW, 32, data width of WDATAn, PWDATA, PRDATA and RDATA.
TIMEOUT, 255, number of PCLKEN-qualified ACCESS cycles before abort. Used only with APB_ARB_TIMEOUT_EN; legal range 1..65535.

Ports:
HCLK  in  1  system clock
HRESETn  in  1  asynchronous active-low reset
PCLKEN  in  1  APB clock enable; APB phase advances only when high (tie to 1 when PCLK = HCLK)
REQ0  in  1  requester 0 command request; held high until ACK0
ADDR0  in  AW  requester 0 address; stable while REQ0 is high
WRITE0  in  1  requester 0 direction, 1 = write
WDATA0  in  DW  requester 0 write data
REQ1, ADDR1, WRITE1, WDATA1  in  1/AW/1/DW  requester 1, same rules as requester 0
ACK0  out  1  one-cycle completion pulse for requester 0
ACK1  out  1  one-cycle completion pulse for requester 1
RDATA  out  DW  read data; valid in the ACK cycle
ERR  out  1  transfer error; valid in the ACK cycle
PADDR  out  AW  APB address
PWRITE  out  1  APB direction
PWDATA  out  DW  APB write data
PSEL  out  1  APB select (single slave-select; decoding is downstream)
PENABLE  out  1  APB enable
PRDATA  in  DW  APB read data
PREADY  in  1  APB ready
PSLVERR  in  1  APB slave error

Behaviour:
- All outputs are registered. All reset to 0 asynchronously on HRESETn low.
- Internal LAST pointer resets to 1, so requester 0 wins the first tie.
- States: IDLE, SETUP, ACCESS.
- IDLE:
  - A request is eligible if REQn is high and ACKn is not asserted this cycle. This masks a requester's REQ during its own ACK cycle.
  - If any request is eligible and PCLKEN is high:
    - Pick the winner. With a single eligible request, that one wins. With both eligible, the requester != LAST wins.
    - Register the winner's ADDR/WRITE/WDATA into PADDR/PWRITE/PWDATA.
    - Set PSEL=1, record the grant index, go to SETUP.
  - If PCLKEN is low, stay in IDLE; no grant is decided.
- SETUP:
  - If PCLKEN is high, set PENABLE=1 and go to ACCESS.
  - Otherwise hold; PSEL stays 1.
- ACCESS:
  - Completion requires PCLKEN & PREADY.
  - On completion, in the same clock edge:
    - ACKgrant=1, RDATA=PRDATA (captured for writes too), ERR=PSLVERR.
    - PSEL=0, PENABLE=0, LAST=grant, go to IDLE.
  - Otherwise hold all APB outputs stable.
- Other output rules:
  - ACKn and ERR are high for exactly one HCLK cycle.
  - RDATA holds its value until the next completion.
  - PADDR/PWRITE/PWDATA hold their values after the transfer (no return to 0).
- Minimum latency with PCLKEN=1 and zero wait states: REQ seen at edge N, then PSEL at N+1, PENABLE at N+2, ACK at N+3.
- One IDLE cycle always separates consecutive transfers.
- Requester protocol:
  - REQn is dropped, or a new command is presented, in the cycle after ACKn.
  - Operand changes while REQn is high and not yet granted are legal; operands are sampled at grant.
- Reset asserted mid-transfer: immediate return to IDLE with all outputs 0. No ACK is issued.
- Unknown or illegal state encodings recover to IDLE.

Optional Feature:
Macro: APB_ARB_TIMEOUT_EN.
- Defined:
  - A counter of width clog2(TIMEOUT+1) clears on entry to ACCESS.
  - It increments on each PCLKEN-qualified ACCESS cycle in which PREADY is low.
  - When the count reaches TIMEOUT with PREADY still low, the transfer completes: ACKgrant=1, ERR=1, RDATA=0, PSEL/PENABLE drop, go to IDLE.
  - A PREADY that is high in the same cycle takes priority (normal completion).
- Not defined: no counter exists, and ACCESS waits for PREADY indefinitely.

Test Plan:
- Single write, PCLKEN=1, zero wait states.
  - Stimulus: REQ0, ADDR0=0x4000_0010, WDATA0=0xA5A5_0001, WRITE0=1, PREADY=1.
  - Response: PSEL=1 at +1 with PADDR/PWDATA matching; PENABLE at +2; ACK0 pulse at +3 with ERR=0; no second transfer.
- Round-robin after reset.
  - Stimulus: REQ0 and REQ1 both high and held.
  - Response: grant order 0, 1, then 0 again after both re-request; a single requester is served back-to-back with one IDLE gap.
- Read with 3 wait states.
  - Stimulus: REQ1 read from ADDR1=0x4000_0200; PREADY low for 3 cycles, then high with PRDATA=0xDEAD_BEEF.
  - Response: PSEL/PENABLE/PADDR stable throughout; ACK1 with RDATA=0xDEAD_BEEF.
- PCLKEN divided by 2, plus slave error.
  - Stimulus: PCLKEN toggling every cycle; PSLVERR=1 in the completion cycle.
  - Response: phases advance only on PCLKEN-high edges; ERR=1 together with ACK.
- Reset mid-ACCESS.
  - Stimulus: assert HRESETn low while PENABLE=1.
  - Response: all outputs 0 immediately; after release, a simultaneous request grants requester 0.
- Timeout (APB_ARB_TIMEOUT_EN defined, TIMEOUT=4).
  - Stimulus: PREADY held low.
  - Response: ACK with ERR=1 and RDATA=0 after 4 ACCESS cycles.
  - Same bench with the macro undefined: no ACK is ever issued.
